// File: rtl/crc_pkg.sv
// Shared types and LFSR step function for the serial CRC generator/checker pair.
// The Seed/Taps defaults here set the polynomial used on the link.
package crc_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DATA  = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } crc_state_e;

   localparam logic [7:0] CRC_SEED_DEF = 8'hD8;
   localparam logic [7:0] CRC_TAPS_DEF = 8'h44;
   localparam int         LFSR_MAX_WD  = 32;

   // One LFSR step: the top stage takes the feedback, lower stages shift down with tapped XOR.
   function automatic logic [LFSR_MAX_WD-1:0] lfsr_step(
      input logic [LFSR_MAX_WD-1:0] cur,
      input logic [LFSR_MAX_WD-1:0] taps,
      input logic                   din,
      input int                     wd
   );
      logic                   fb;
      logic [LFSR_MAX_WD-1:0] shr;
      logic [LFSR_MAX_WD-1:0] nxt;
      fb  = din ^ cur[0];
      shr = cur >> 1;
      nxt = '0;
      for (int i = 0; i < LFSR_MAX_WD; i++) begin
         if (i < wd - 1)
            nxt[i] = shr[i] ^ (taps[i] & fb);
         else if (i == wd - 1)
            nxt[i] = fb;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/crc_serial_checker_if.sv
// Serial link bundle between the deserialiser and the CRC checker.
// The master drives the payload/CRC bit streams; the slave returns status.
interface crc_serial_checker_if;
   logic data;
   logic active;
   logic crc_in;
   logic crc_vld;
   logic busy;
   logic crc_ok;
   logic crc_err;
   logic frame_err;

   modport master (
      output data, active, crc_in, crc_vld,
      input  busy, crc_ok, crc_err, frame_err
   );

   modport slave (
      input  data, active, crc_in, crc_vld,
      output busy, crc_ok, crc_err, frame_err
   );
endinterface

// File: rtl/crc_lfsr_core.sv
// LFSR register with load/step/shift controls, shared by the serial CRC generator and checker
// so both ends of the link always agree on the polynomial. Priority: load > step > shift.
module crc_lfsr_core
   import crc_pkg::*;
#(
   parameter int            WD   = 8,
   parameter logic [WD-1:0] SEED = WD'(CRC_SEED_DEF),
   parameter logic [WD-1:0] TAPS = WD'(CRC_TAPS_DEF)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   input  logic step_i,
   input  logic shift_i,
   input  logic data_i,
   output logic lsb_o
);

   logic [WD-1:0] lfsr_q;
   logic [WD-1:0] lfsr_d;
   logic [WD-1:0] stepped;

   assign stepped = WD'(lfsr_step(LFSR_MAX_WD'(lfsr_q), LFSR_MAX_WD'(TAPS), data_i, WD));

   always_comb begin
      lfsr_d = lfsr_q;
      if (load_i)
         lfsr_d = SEED;
      else if (step_i)
         lfsr_d = stepped;
      else if (shift_i)
         lfsr_d = lfsr_q >> 1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         lfsr_q <= SEED;
      else
         lfsr_q <= lfsr_d;
   end

   assign lsb_o = lfsr_q[0];

endmodule

// File: rtl/crc_serial_checker.sv
// Receive-side serial CRC checker: recomputes the CRC over the payload and compares the received
// CRC bit-serially. Optional error counter output enabled by defining CRC_ERR_CNT_EN.
//
// state | meaning
// IDLE  | LFSR at seed, waiting for payload bit 0
// DATA  | accumulating payload bits into the LFSR
// CHECK | comparing received CRC bits against LFSR LSB, gaps allowed
// DONE  | one-cycle verdict; a payload bit here starts the next frame
module crc_serial_checker
   import crc_pkg::*;
#(
   parameter int                 LFSR_WD = 8,
   parameter int                 DATA_WD = 8,
   parameter logic [LFSR_WD-1:0] SEED    = LFSR_WD'(CRC_SEED_DEF),
   parameter logic [LFSR_WD-1:0] TAPS    = LFSR_WD'(CRC_TAPS_DEF)
) (
   input logic                  clk_i,
   input logic                  rst_ni,
   crc_serial_checker_if.slave  bus
`ifdef CRC_ERR_CNT_EN
   ,
   output logic [7:0]           err_cnt_o
`endif
);

   localparam int CNT_MAX = (DATA_WD > LFSR_WD) ? DATA_WD : LFSR_WD;
   localparam int CNT_WD  = $clog2(CNT_MAX + 1);

   crc_state_e        state_q, state_d;
   logic [CNT_WD-1:0] cnt_q, cnt_d;
   logic              flag_q, flag_d;
   logic              busy_q, busy_d;
   logic              ok_q, ok_d;
   logic              err_q, err_d;
   logic              ferr_q, ferr_d;
   logic              acc;
   logic              load, step, shift;
   logic              lsb;
   logic              last_data, last_crc;

   assign last_data = (cnt_q == CNT_WD'(DATA_WD - 1));
   assign last_crc  = (cnt_q == CNT_WD'(LFSR_WD - 1));

   crc_lfsr_core #(
      .WD   (LFSR_WD),
      .SEED (SEED),
      .TAPS (TAPS)
   ) u_lfsr (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (load),
      .step_i  (step),
      .shift_i (shift),
      .data_i  (bus.data),
      .lsb_o   (lsb)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         state_q <= IDLE;
      else
         state_q <= state_d;
   end

   // Protocol violations always win over frame progress.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.crc_vld)
               state_d = IDLE;
            else if (bus.active)
               state_d = last_data ? CHECK : DATA;
            else
               state_d = IDLE;
         end
         DATA: begin
            if (bus.crc_vld || !bus.active)
               state_d = IDLE;
            else if (last_data)
               state_d = CHECK;
         end
         CHECK: begin
            if (bus.active)
               state_d = IDLE;
            else if (bus.crc_vld && last_crc)
               state_d = DONE;
         end
      endcase
   end

   always_comb begin
      ferr_d = 1'b0;
      step   = 1'b0;
      shift  = 1'b0;
      cnt_d  = cnt_q;
      acc    = flag_q;
      unique case (state_q)
         IDLE, DONE: begin
            if (bus.crc_vld) begin
               ferr_d = 1'b1;
            end else if (bus.active) begin
               step  = 1'b1;
               cnt_d = last_data ? '0 : cnt_q + CNT_WD'(1);
            end
         end
         DATA: begin
            if (bus.crc_vld || !bus.active) begin
               ferr_d = 1'b1;
               cnt_d  = '0;
            end else begin
               step  = 1'b1;
               cnt_d = last_data ? '0 : cnt_q + CNT_WD'(1);
            end
         end
         CHECK: begin
            if (bus.active) begin
               ferr_d = 1'b1;
               cnt_d  = '0;
            end else if (bus.crc_vld) begin
               acc = flag_q | (bus.crc_in ^ lsb);
               if (last_crc) begin
                  cnt_d = '0;
               end else begin
                  shift = 1'b1;
                  cnt_d = cnt_q + CNT_WD'(1);
               end
            end
         end
      endcase
      // Reseeding on entry to DONE lets a payload bit in DONE step from the seed.
      load   = !step && ((state_d == IDLE) || (state_d == DONE));
      flag_d = (state_d == CHECK) && acc;
      busy_d = (state_d == DATA) || (state_d == CHECK);
      ok_d   = (state_d == DONE) && !acc;
      err_d  = (state_d == DONE) && acc;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         flag_q <= 1'b0;
         busy_q <= 1'b0;
         ok_q   <= 1'b0;
         err_q  <= 1'b0;
         ferr_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         flag_q <= flag_d;
         busy_q <= busy_d;
         ok_q   <= ok_d;
         err_q  <= err_d;
         ferr_q <= ferr_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.crc_ok    = ok_q;
   assign bus.crc_err   = err_q;
   assign bus.frame_err = ferr_q;

`ifdef CRC_ERR_CNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)
         err_cnt_q <= '0;
      else if ((err_d || ferr_d) && (err_cnt_q != 8'hFF))
         err_cnt_q <= err_cnt_q + 8'd1;
   end

   assign err_cnt_o = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_serial_checker.sv
// Directed self-checking bench for crc_serial_checker; exercises the counter when CRC_ERR_CNT_EN is defined.
module tb_crc_serial_checker;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad   = 0;
   int   n_ok = 0, n_err = 0, n_ferr = 0, n_busy = 0;

   crc_serial_checker_if bus();
`ifdef CRC_ERR_CNT_EN
   logic [7:0] err_cnt;
`endif

   crc_serial_checker dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .bus       (bus)
`ifdef CRC_ERR_CNT_EN
      ,
      .err_cnt_o (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.crc_ok)    n_ok++;
      if (bus.crc_err)   n_err++;
      if (bus.frame_err) n_ferr++;
      if (bus.busy)      n_busy++;
   end

   function automatic logic [7:0] model_crc(input logic [7:0] d);
      logic [7:0] l, n, taps;
      logic       fb;
      l    = 8'hD8;
      taps = 8'h44;
      for (int b = 0; b < 8; b++) begin
         fb   = d[b] ^ l[0];
         n[7] = fb;
         for (int j = 0; j < 7; j++) n[j] = l[j+1] ^ (taps[j] & fb);
         l = n;
      end
      return l;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_data(input logic [7:0] d, input int nbits);
      for (int i = 0; i < nbits; i++) begin
         bus.active = 1'b1;
         bus.data   = d[i];
         tick();
      end
      bus.active = 1'b0;
      bus.data   = 1'b0;
   endtask

   task automatic send_crc(input logic [7:0] c, input int nbits, input int gap_at, input int gap_len);
      for (int i = 0; i < nbits; i++) begin
         if (i == gap_at) begin
            bus.crc_vld = 1'b0;
            repeat (gap_len) tick();
         end
         bus.crc_vld = 1'b1;
         bus.crc_in  = c[i];
         tick();
      end
      bus.crc_vld = 1'b0;
      bus.crc_in  = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      total++;
      if ({bus.busy, bus.crc_ok, bus.crc_err, bus.frame_err} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_outputs: got %b want 0000", {bus.busy, bus.crc_ok, bus.crc_err, bus.frame_err});
      end
`ifdef CRC_ERR_CNT_EN
      total++;
      if (err_cnt !== 8'h00) begin
         bad++;
         $display("FAIL reset_err_cnt: got %h want 00", err_cnt);
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_good_frame();
      int b0, o0;
      b0 = n_busy;
      o0 = n_ok;
      send_data(8'h00, 8);
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL good_busy_check: got %b want 1", bus.busy);
      end
      send_crc(8'h14, 8, -1, 0);
      total++;
      if ({bus.crc_ok, bus.crc_err, bus.frame_err, bus.busy} !== 4'b1000) begin
         bad++;
         $display("FAIL good_verdict: got %b want 1000", {bus.crc_ok, bus.crc_err, bus.frame_err, bus.busy});
      end
      total++;
      if (n_busy - b0 !== 15) begin
         bad++;
         $display("FAIL good_busy_cycles: got %0d want 15", n_busy - b0);
      end
      tick();
      total++;
      if (bus.crc_ok !== 1'b0 || n_ok - o0 !== 1) begin
         bad++;
         $display("FAIL good_pulse_width: got ok=%b count=%0d want ok=0 count=1", bus.crc_ok, n_ok - o0);
      end
   endtask

   task automatic test_bad_crc();
`ifdef CRC_ERR_CNT_EN
      total++;
      if (err_cnt !== 8'h00) begin
         bad++;
         $display("FAIL bad_cnt_before: got %h want 00", err_cnt);
      end
`endif
      send_data(8'h00, 8);
      send_crc(8'h15, 8, -1, 0);
      total++;
      if ({bus.crc_ok, bus.crc_err, bus.frame_err} !== 3'b010) begin
         bad++;
         $display("FAIL bad_verdict: got %b want 010", {bus.crc_ok, bus.crc_err, bus.frame_err});
      end
`ifdef CRC_ERR_CNT_EN
      total++;
      if (err_cnt !== 8'h01) begin
         bad++;
         $display("FAIL bad_cnt_after: got %h want 01", err_cnt);
      end
`endif
      tick();
   endtask

   task automatic test_back_to_back();
      logic [7:0] pl [10];
      int o0, e0, f0;
      pl = '{8'hA5, 8'h3C, 8'hFF, 8'h01, 8'h80, 8'h5A, 8'hC3, 8'h7E, 8'h12, 8'hE7};
      o0 = n_ok;
      e0 = n_err;
      f0 = n_ferr;
      for (int i = 0; i < 10; i++) begin
         send_data(pl[i], 8);
         send_crc(model_crc(pl[i]), 8, -1, 0);
      end
      tick();
      tick();
      total++;
      if (n_ok - o0 !== 10) begin
         bad++;
         $display("FAIL b2b_ok_count: got %0d want 10", n_ok - o0);
      end
      total++;
      if (n_ferr - f0 !== 0) begin
         bad++;
         $display("FAIL b2b_frame_err: got %0d want 0", n_ferr - f0);
      end
      total++;
      if (n_err - e0 !== 0) begin
         bad++;
         $display("FAIL b2b_crc_err: got %0d want 0", n_err - e0);
      end
   endtask

   task automatic test_short_frame();
      send_data(8'hFF, 5);
      tick();
      total++;
      if ({bus.frame_err, bus.busy, bus.crc_ok, bus.crc_err} !== 4'b1000) begin
         bad++;
         $display("FAIL short_ferr: got %b want 1000", {bus.frame_err, bus.busy, bus.crc_ok, bus.crc_err});
      end
      tick();
      total++;
      if (bus.frame_err !== 1'b0) begin
         bad++;
         $display("FAIL short_ferr_width: got %b want 0", bus.frame_err);
      end
      send_data(8'h00, 8);
      send_crc(8'h14, 8, -1, 0);
      total++;
      if ({bus.crc_ok, bus.crc_err} !== 2'b10) begin
         bad++;
         $display("FAIL short_recover: got %b want 10", {bus.crc_ok, bus.crc_err});
      end
      tick();
   endtask

   task automatic test_protocol();
      int o0, e0;
      bus.crc_vld = 1'b1;
      tick();
      bus.crc_vld = 1'b0;
      total++;
      if ({bus.frame_err, bus.busy} !== 2'b10) begin
         bad++;
         $display("FAIL proto_vld_idle: got %b want 10", {bus.frame_err, bus.busy});
      end
      tick();
      bus.crc_vld = 1'b1;
      bus.active  = 1'b1;
      tick();
      bus.crc_vld = 1'b0;
      bus.active  = 1'b0;
      total++;
      if ({bus.frame_err, bus.busy} !== 2'b10) begin
         bad++;
         $display("FAIL proto_both_high: got %b want 10", {bus.frame_err, bus.busy});
      end
      tick();
      o0 = n_ok;
      e0 = n_err;
      send_data(8'h00, 8);
      send_crc(8'h14, 3, -1, 0);
      bus.active = 1'b1;
      tick();
      bus.active = 1'b0;
      total++;
      if ({bus.frame_err, bus.busy} !== 2'b10) begin
         bad++;
         $display("FAIL proto_active_check: got %b want 10", {bus.frame_err, bus.busy});
      end
      repeat (3) tick();
      total++;
      if (n_ok - o0 !== 0 || n_err - e0 !== 0) begin
         bad++;
         $display("FAIL proto_no_verdict: got ok=%0d err=%0d want 0 0", n_ok - o0, n_err - e0);
      end
      send_data(8'h00, 8);
      send_crc(8'h14, 8, 4, 3);
      total++;
      if ({bus.crc_ok, bus.crc_err, bus.frame_err} !== 3'b100) begin
         bad++;
         $display("FAIL proto_gap: got %b want 100", {bus.crc_ok, bus.crc_err, bus.frame_err});
      end
      tick();
   endtask

   task automatic test_reset_mid();
      int o0, e0, f0;
      o0 = n_ok;
      e0 = n_err;
      f0 = n_ferr;
      send_data(8'h00, 8);
      send_crc(8'h14, 4, -1, 0);
      total++;
      if (bus.busy !== 1'b1) begin
         bad++;
         $display("FAIL rstmid_busy_before: got %b want 1", bus.busy);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({bus.busy, bus.crc_ok, bus.crc_err, bus.frame_err} !== 4'b0000) begin
         bad++;
         $display("FAIL rstmid_async: got %b want 0000", {bus.busy, bus.crc_ok, bus.crc_err, bus.frame_err});
      end
      repeat (2) tick();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) tick();
      total++;
      if (n_ok - o0 !== 0 || n_err - e0 !== 0 || n_ferr - f0 !== 0) begin
         bad++;
         $display("FAIL rstmid_silent: got ok=%0d err=%0d ferr=%0d want 0 0 0", n_ok - o0, n_err - e0, n_ferr - f0);
      end
      send_data(8'h00, 8);
      send_crc(8'h14, 8, -1, 0);
      total++;
      if ({bus.crc_ok, bus.crc_err} !== 2'b10) begin
         bad++;
         $display("FAIL rstmid_next_frame: got %b want 10", {bus.crc_ok, bus.crc_err});
      end
      tick();
   endtask

`ifdef CRC_ERR_CNT_EN
   task automatic test_err_cnt_sat();
      bus.crc_vld = 1'b1;
      repeat (10) tick();
      total++;
      if (err_cnt !== 8'd10) begin
         bad++;
         $display("FAIL cnt_ten: got %0d want 10", err_cnt);
      end
      repeat (250) tick();
      total++;
      if (err_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL cnt_saturate: got %h want ff", err_cnt);
      end
      bus.crc_vld = 1'b0;
      repeat (2) tick();
      total++;
      if (err_cnt !== 8'hFF) begin
         bad++;
         $display("FAIL cnt_hold: got %h want ff", err_cnt);
      end
   endtask
`endif

   initial begin
      bus.data    = 1'b0;
      bus.active  = 1'b0;
      bus.crc_in  = 1'b0;
      bus.crc_vld = 1'b0;
      test_reset();
      test_good_frame();
      test_bad_crc();
      test_back_to_back();
      test_short_frame();
      test_protocol();
      test_reset_mid();
`ifdef CRC_ERR_CNT_EN
      test_err_cnt_sat();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
